aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
- Iterative AES-128 round sequencer; computes one round per clock.
- Owns the 128-bit state register and the round counter, and drives the round-key index to the key-schedule storage.
- Sequences the combinational ShiftRow/SubByte/MixColumns/AddRoundKey datapath (inverse set optional).
- Sits between the host load/unload interface and the key-expansion block.

Parameters:
- NR, 10, number of AES rounds (AES-128 only; other values unsupported).
- RK_IDX_W, 4, width of the round-key index.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  host presents a block.
- in_ready  out  1  block accepted when in_valid && in_ready.
- in_data  in  128  plaintext/ciphertext; bits [127:120] = byte 0, FIPS-197 column-major order.
- decrypt  in  1  sampled on accept; 1 = inverse cipher (honoured only with AES_DECRYPT_EN).
- rk_idx  out  RK_IDX_W  round-key index requested this cycle.
- rk_data  in  128  round key for rk_idx, valid combinationally in the same cycle.
- out_valid  out  1  result available.
- out_ready  in  1  host consumes result when out_valid && out_ready.
- out_data  out  128  result block; holds the state register.
- busy  out  1  high in ROUND or DONE.

Behaviour:
- Reset: FSM to IDLE; state register, round counter, out_data and mode flag to 0; in_ready=1, out_valid=0, busy=0, rk_idx=0.
- Reset asserted in any state aborts the operation the same edge. The partial result is discarded and never flagged valid.
- IDLE:
  - in_ready=1; rk_idx = 0 (encrypt) or NR (decrypt input).
  - On accept: state <= in_data ^ rk_data; mode <= decrypt; round <= 1; go to ROUND.
- ROUND:
  - in_ready=0.
  - Encrypt: rk_idx = round. state <= AddRoundKey(MixColumns(ShiftRow(SubByte(state))), rk_data). MixColumns is skipped when round==NR.
  - Decrypt: rk_idx = NR-round. state <= InvMixColumns(AddRoundKey(InvSubByte(InvShiftRow(state)), rk_data)). InvMixColumns is skipped when round==NR.
  - round increments each cycle. After the round==NR update, go to DONE.
- DONE:
  - out_valid=1 and out_data stable until out_ready.
  - On out_valid && out_ready: go to IDLE; out_valid falls next cycle.
- Latency: accept at edge T; out_valid high in the cycle after edge T+NR (11 cycles). Throughput: one block per 12 cycles minimum.
- in_valid while busy is ignored; no new block is accepted in the same cycle as the result handshake.
- out_ready held high before DONE has no effect.
- decrypt changing mid-operation has no effect; only the value sampled at accept is used.
- rk_idx never exceeds NR. The round counter saturates, with no wrap past NR.

Optional Feature:
- Macro: AES_DECRYPT_EN.
- Defined: inverse datapath instantiated; decrypt honoured as above.
- Undefined: inverse logic absent; decrypt ignored (treated as 0); rk_idx in IDLE is always 0.

Decomposition:
- Shared include aes_defs.vh holds:
  - constants AES_NR=10 and AES_BLK_W=128;
  - FSM state encodings ST_IDLE=2'd0, ST_ROUND=2'd1, ST_DONE=2'd2;
  - a byte-slice helper macro.
- One natural sub-module, aes_round: a purely combinational single round.
  - Inputs: state, round key, last_round, inv.
  - Instantiates SubByte/ShiftRow/MixColumns and, under the macro, their inverses.
- aes_round_ctrl holds only the FSM, counter and registers.

Test Plan:
- FIPS-197 C.1 encrypt: key 000102030405060708090a0b0c0d0e0f (bench key-schedule model), in_data 00112233445566778899aabbccddeeff.
  - Response: out_data 69c4e0d86a7b0430d8cdb78070b4c55a.
  - out_valid exactly 11 cycles after accept; rk_idx sequence 0,1,…,10.
- With AES_DECRYPT_EN, decrypt=1, in_data 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Response: out_data 00112233445566778899aabbccddeeff; rk_idx sequence 10,9,…,0.
- Backpressure: out_ready=0 for 5 cycles after out_valid.
  - out_data and out_valid held constant.
  - in_ready=0, and a second in_valid pulse is not accepted.
  - out_ready=1 → IDLE next cycle.
- Reset mid-operation: assert rst at round 5.
  - Next cycle: out_valid=0, busy=0, in_ready=1, out_data=0.
  - A new block then yields the correct C.1 result.
- Back-to-back: two FIPS-197 blocks with in_valid and out_ready held high.
  - Accepts spaced 12 cycles apart; both results correct.
  - decrypt toggled mid-run does not alter the first result.
- Without AES_DECRYPT_EN: decrypt=1 with the C.1 plaintext.
  - Response: encrypt result 69c4e0d86a7b0430d8cdb78070b4c55a.

Source files
------------

// File: rtl/aes_round_ctrl_pkg.sv
// Shared AES-128 constants, FSM encoding and GF(2^8) round helpers.
// Inverse-cipher helpers exist only when AES_DECRYPT_EN is defined.
package aes_round_ctrl_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_BLK_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } st_e;

  typedef logic [AES_BLK_W-1:0] blk_t;

  // Byte i of a block, byte 0 in the top bits (column-major order).
  function automatic logic [7:0] blk_byte(
    input blk_t b,
    input int   i
  );
    return b[AES_BLK_W-1-8*i -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(
    input logic [7:0] a,
    input int unsigned n
  );
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2)
             ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic blk_t sub_bytes(input blk_t b);
    blk_t r;
    for (int i = 0; i < 16; i++)
      r[AES_BLK_W-1-8*i -: 8] = sbox(blk_byte(b, i));
    return r;
  endfunction

  function automatic blk_t shift_rows(input blk_t b);
    blk_t r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[AES_BLK_W-1-8*(w+4*c) -: 8] =
          blk_byte(b, w + 4*((c + w) % 4));
    return r;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {
      xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
      a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
      a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
      xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
    };
  endfunction

  function automatic blk_t mix_columns(input blk_t b);
    blk_t r;
    for (int c = 0; c < 4; c++)
      r[AES_BLK_W-1-32*c -: 32] = mix_col(b[AES_BLK_W-1-32*c -: 32]);
    return r;
  endfunction

`ifdef AES_DECRYPT_EN
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic blk_t inv_sub_bytes(input blk_t b);
    blk_t r;
    for (int i = 0; i < 16; i++)
      r[AES_BLK_W-1-8*i -: 8] = inv_sbox(blk_byte(b, i));
    return r;
  endfunction

  function automatic blk_t inv_shift_rows(input blk_t b);
    blk_t r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[AES_BLK_W-1-8*(w+4*c) -: 8] =
          blk_byte(b, w + 4*((c - w + 4) % 4));
    return r;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {
      gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
        ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
      gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
        ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
      gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
        ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
      gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
        ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)
    };
  endfunction

  function automatic blk_t inv_mix_columns(input blk_t b);
    blk_t r;
    for (int c = 0; c < 4; c++)
      r[AES_BLK_W-1-32*c -: 32] =
        inv_mix_col(b[AES_BLK_W-1-32*c -: 32]);
    return r;
  endfunction
`endif

endpackage

// File: rtl/aes_round_ctrl_round.sv
// Single combinational AES round; inverse path present only with
// AES_DECRYPT_EN defined.
module aes_round
  import aes_round_ctrl_pkg::*;
(
  input  logic [AES_BLK_W-1:0] state,
  input  logic [AES_BLK_W-1:0] rkey,
  input  logic                 last_round,
  input  logic                 inv,
  output logic [AES_BLK_W-1:0] next_state
);

  blk_t sr;
  blk_t enc;

  assign sr  = shift_rows(sub_bytes(state));
  assign enc = (last_round ? sr : mix_columns(sr)) ^ rkey;

`ifdef AES_DECRYPT_EN
  blk_t ark;
  blk_t dec;

  assign ark = inv_sub_bytes(inv_shift_rows(state)) ^ rkey;
  assign dec = last_round ? ark : inv_mix_columns(ark);

  assign next_state = inv ? dec : enc;
`else
  logic unused_inv;

  assign unused_inv = inv;
  assign next_state = enc;
`endif

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer: one round per clock.
// Define AES_DECRYPT_EN to honour the decrypt input.
module aes_round_ctrl
  import aes_round_ctrl_pkg::*;
#(
  parameter int NR       = 10,
  parameter int RK_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [127:0]         in_data,
  input  logic                 decrypt,
  output logic [RK_IDX_W-1:0]  rk_idx,
  input  logic [127:0]         rk_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [127:0]         out_data,
  output logic                 busy
);

  localparam logic [RK_IDX_W-1:0] NR_IDX = RK_IDX_W'(NR);

  st_e                 st_q;
  blk_t                state_q;
  logic [RK_IDX_W-1:0] round_q;
  logic                mode_q;
  logic                dec_in;
  logic                last;
  blk_t                rnd_out;

`ifdef AES_DECRYPT_EN
  assign dec_in = decrypt;
`else
  logic unused_decrypt;

  assign unused_decrypt = decrypt;
  assign dec_in         = 1'b0;
`endif

  assign last     = (round_q == NR_IDX);
  assign out_data = state_q;

  // Key index must be combinational: rk_data answers in the same cycle.
  always_comb begin
    rk_idx = round_q;
    if (st_q == ST_IDLE)
      rk_idx = dec_in ? NR_IDX : '0;
    else if (mode_q)
      rk_idx = NR_IDX - round_q;
  end

  aes_round u_round (
    .state      (state_q),
    .rkey       (rk_data),
    .last_round (last),
    .inv        (mode_q),
    .next_state (rnd_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= ST_IDLE;
      state_q   <= '0;
      round_q   <= '0;
      mode_q    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (st_q)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            state_q  <= in_data ^ rk_data;
            mode_q   <= dec_in;
            round_q  <= RK_IDX_W'(1);
            st_q     <= ST_ROUND;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_ROUND: begin
          state_q <= rnd_out;
          if (last) begin
            st_q      <= ST_DONE;
            out_valid <= 1'b1;
          end else begin
            round_q <= round_q + RK_IDX_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            st_q      <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          st_q      <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl against a byte-array AES model.
// Build with AES_DECRYPT_EN to exercise the inverse cipher.
module tb_aes_round_ctrl;

  localparam int NR = 10;
`ifdef AES_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         decrypt;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rk    [11];
  logic [3:0]   rk_seen [$];
  int           acc_t [$];
  logic [127:0] res_q [$];
  int           cyc = 0;
  int           passed = 0;
  int           total = 0;
  logic [3:0]   rk_max = '0;

  aes_round_ctrl #(.NR(10), .RK_IDX_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .decrypt   (decrypt),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  assign rk_data = (rk_idx <= 4'd10) ? rk[rk_idx] : '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observer between the driving negedge and the next posedge.
  always begin
    @(negedge clk);
    #2;
    cyc++;
    if (!rst && in_valid && in_ready) acc_t.push_back(cyc);
    if (!rst && out_valid && out_ready) res_q.push_back(out_data);
    if (!rst && rk_idx > rk_max) rk_max = rk_idx;
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] tb_mul(input logic [7:0] a,
                                        input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] coef(input int d, input bit inv);
    logic [7:0] f [4];
    logic [7:0] g [4];
    f = '{8'h02, 8'h03, 8'h01, 8'h01};
    g = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    return inv ? g[d] : f[d];
  endfunction

  function automatic logic [7:0] byt(input logic [127:0] b, input int i);
    return b[127-8*i -: 8];
  endfunction

  task automatic build_tables();
    logic [7:0] iv, c, s;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      iv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (tb_mul(8'(a), 8'(b)) == 8'h01) iv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = iv[i] ^ iv[(i+4)%8] ^ iv[(i+5)%8]
             ^ iv[(i+6)%8] ^ iv[(i+7)%8] ^ c[i];
      sbox[a]  = s;
      isbox[s] = 8'(a);
    end
  endtask

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]}
            ^ {rc, 24'h0};
        rc = tb_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic void mix(inout logic [7:0] s [16], input bit inv);
    logic [7:0] t [16];
    logic [7:0] acc;
    t = s;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ tb_mul(coef((k - w + 4) % 4, inv), t[k+4*c]);
        s[w+4*c] = acc;
      end
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) s[i] = byt(pt, i) ^ byt(rk[0], i);
    for (int rd = 1; rd <= NR; rd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) s[w+4*c] = t[w+4*((c+w)%4)];
      if (rd != NR) mix(s, 1'b0);
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ byt(rk[rd], i);
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
    return r;
  endfunction

  function automatic logic [127:0] model_dec(input logic [127:0] ct);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) s[i] = byt(ct, i) ^ byt(rk[NR], i);
    for (int rd = NR - 1; rd >= 0; rd--) begin
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[w+4*c] = s[w+4*((c-w+4)%4)];
      for (int i = 0; i < 16; i++) s[i] = isbox[t[i]] ^ byt(rk[rd], i);
      if (rd != 0) mix(s, 1'b1);
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
    return r;
  endfunction

  // ---------------- stimulus ----------------
  task automatic run_block(input logic [127:0] din, input bit dec,
                           input int hold,
                           output logic [127:0] res, output int lat);
    int n;
    rk_seen.delete();
    @(negedge clk);
    in_data = din; decrypt = dec; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    rk_seen.push_back(rk_idx);
    @(negedge clk);
    in_valid = 1'b0; decrypt = ~dec;
    in_data = {$urandom, $urandom, $urandom, $urandom};
    lat = 1;
    while (!out_valid && lat < 30) begin
      rk_seen.push_back(rk_idx);
      @(negedge clk);
      lat++;
    end
    res = out_data;
    for (int k = 0; k < hold; k++) begin
      in_valid = (k == 1);
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== res || in_ready !== 1'b0)
        $display("FAIL hold[%0d]: valid=%b ready=%b data=%h want 1 0 %h",
                 k, out_valid, in_ready, out_data, res);
      else passed++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL release: valid=%b ready=%b busy=%b want 0 1 0",
               out_valid, in_ready, busy);
    else passed++;
  endtask

  task automatic check_block(input string nm, input logic [127:0] res,
                             input int lat, input logic [127:0] exp,
                             input bit inv);
    bit bad;
    total++;
    if (res !== exp) $display("FAIL %s data: got %h want %h", nm, res, exp);
    else passed++;
    total++;
    if (lat !== NR + 1) $display("FAIL %s latency: got %0d want %0d",
                                 nm, lat, NR + 1);
    else passed++;
    bad = (rk_seen.size() != NR + 1);
    for (int i = 0; i < rk_seen.size() && i <= NR; i++)
      if (rk_seen[i] !== 4'(inv ? NR - i : i)) bad = 1'b1;
    total++;
    if (bad) $display("FAIL %s rk_idx seq: len %0d first %0d inv %b",
                      nm, rk_seen.size(),
                      rk_seen.size() > 0 ? rk_seen[0] : 4'hf, inv);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; decrypt = 1'b0;
    in_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset flags: ready=%b valid=%b busy=%b want 1 0 0",
               in_ready, out_valid, busy);
    else passed++;
    total++;
    if (out_data !== '0 || rk_idx !== 4'd0)
      $display("FAIL reset data: data=%h rk_idx=%0d want 0 0",
               out_data, rk_idx);
    else passed++;
  endtask

  task automatic test_fips();
    logic [127:0] res;
    int lat;
    load_key(C1_KEY);
    run_block(C1_PT, 1'b0, 0, res, lat);
    check_block("c1_enc", res, lat, C1_CT, 1'b0);
    total++;
    if (res !== model_enc(C1_PT))
      $display("FAIL c1_model: got %h want %h", res, model_enc(C1_PT));
    else passed++;
    run_block(DEC_EN ? C1_CT : C1_PT, 1'b1, 0, res, lat);
    check_block("c1_dec_in", res, lat, DEC_EN ? C1_PT : C1_CT, DEC_EN);
  endtask

  task automatic test_backpressure();
    logic [127:0] res;
    int lat;
    run_block(B_PT, 1'b0, 5, res, lat);
    check_block("bp", res, lat, model_enc(B_PT), 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [127:0] res;
    int lat, n;
    bit seen;
    @(negedge clk);
    in_data = C1_PT; decrypt = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (rk_idx !== 4'd5 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (rk_idx !== 4'd5 || busy !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL mid_round: rk_idx=%0d busy=%b valid=%b want 5 1 0",
               rk_idx, busy, out_valid);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL abort flags: valid=%b busy=%b ready=%b want 0 0 1",
               out_valid, busy, in_ready);
    else passed++;
    total++;
    if (out_data !== '0)
      $display("FAIL abort data: got %h want 0", out_data);
    else passed++;
    seen = 1'b0;
    repeat (12) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    total++;
    if (seen) $display("FAIL abort stray valid: got 1 want 0");
    else passed++;
    run_block(C1_PT, 1'b0, 1, res, lat);
    check_block("after_abort", res, lat, C1_CT, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n, gap;
    logic [127:0] r0, r1;
    acc_t.delete(); res_q.delete();
    @(negedge clk);
    in_data = C1_PT; decrypt = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (acc_t.size() < 1 && n < 30) begin @(negedge clk); n++; end
    in_data = B_PT;
    repeat (4) begin decrypt = ~decrypt; @(negedge clk); end
    decrypt = 1'b0;
    n = 0;
    while (acc_t.size() < 2 && n < 40) begin @(negedge clk); n++; end
    in_valid = 1'b0;
    n = 0;
    while (res_q.size() < 2 && n < 40) begin @(negedge clk); n++; end
    out_ready = 1'b0;
    @(negedge clk);
    gap = (acc_t.size() >= 2) ? acc_t[1] - acc_t[0] : -1;
    r0  = (res_q.size() >= 1) ? res_q[0] : 'x;
    r1  = (res_q.size() >= 2) ? res_q[1] : 'x;
    total++;
    if (gap !== 12 || acc_t.size() !== 2)
      $display("FAIL b2b spacing: accepts=%0d gap=%0d want 2 12",
               acc_t.size(), gap);
    else passed++;
    total++;
    if (r0 !== C1_CT) $display("FAIL b2b first: got %h want %h", r0, C1_CT);
    else passed++;
    total++;
    if (r1 !== model_enc(B_PT))
      $display("FAIL b2b second: got %h want %h", r1, model_enc(B_PT));
    else passed++;
  endtask

  task automatic test_random();
    logic [127:0] key, pt, res, exp;
    int lat;
    bit d, eff;
    for (int n = 0; n < 6; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      d   = 1'($urandom_range(0, 1));
      eff = d && DEC_EN;
      load_key(key);
      exp = eff ? model_dec(pt) : model_enc(pt);
      run_block(pt, d, $urandom_range(0, 3), res, lat);
      check_block($sformatf("rand%0d", n), res, lat, exp, eff);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; decrypt = 1'b0;
    in_data = '0;
    build_tables();
    load_key(C1_KEY);
    test_reset();
    test_fips();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    total++;
    if (rk_max > 4'd10) $display("FAIL rk_idx bound: max %0d want <= 10",
                                 rk_max);
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
